// File: rtl/datapath_2.sv
// Single-bus 32-bit CPU datapath: bus mux, 16x32 register file, PC/IR/MAR/MDR/Y/Z,
// 512x32 memory, ALU with 64-bit Z, branch-condition flag and an output port.
module datapath_2 (
  input  logic        clk,
  input  logic        clr,
  input  logic        PCout,
  input  logic        Zlowout,
  input  logic        MDRout,
  input  logic        MBIout,
  input  logic        Cout,
  input  logic        Rout,
  input  logic        BAout,
  input  logic        PCin,
  input  logic        IRin,
  input  logic        MARin,
  input  logic        MDRin,
  input  logic        Yin,
  input  logic        Zin,
  input  logic        Rin,
  input  logic        CONin,
  input  logic        OutportIn,
  input  logic        Gra,
  input  logic        Grb,
  input  logic        Grc,
  input  logic        Read,
  input  logic        Write,
  input  logic [4:0]  OpCode,
  input  logic [31:0] manualBusInput,
  output logic [31:0] BusMuxOut,
  output logic [31:0] OutportData,
  output logic        CON
);

  localparam logic [4:0] OP_ADD  = 5'd2;
  localparam logic [4:0] OP_SUB  = 5'd3;
  localparam logic [4:0] OP_SHR  = 5'd4;
  localparam logic [4:0] OP_SHRA = 5'd5;
  localparam logic [4:0] OP_SHL  = 5'd6;
  localparam logic [4:0] OP_ROR  = 5'd7;
  localparam logic [4:0] OP_ROL  = 5'd8;
  localparam logic [4:0] OP_AND  = 5'd9;
  localparam logic [4:0] OP_OR   = 5'd10;
  localparam logic [4:0] OP_NEG  = 5'd11;
  localparam logic [4:0] OP_INC  = 5'd12;
  localparam logic [4:0] OP_MUL  = 5'd13;
  localparam logic [4:0] OP_NOT  = 5'd14;

  logic [31:0] pc_q,   pc_d;
  logic [31:0] ir_q,   ir_d;
  logic [31:0] mar_q,  mar_d;
  logic [31:0] mdr_q,  mdr_d;
  logic [31:0] y_q,    y_d;
  logic [63:0] z_q,    z_d;
  logic        con_q,  con_d;
  logic [31:0] outp_q, outp_d;
  logic [31:0] r_q [16];
  logic [31:0] r_d [16];

  logic [31:0] mem [512];
  logic [31:0] mem_rdata;

  logic [31:0] bus;
  logic [3:0]  reg_idx;
  logic [31:0] c_sext;
  logic [63:0] alu_res;
  logic        con_eval;

  // IR fields: Ra, Rb, Rc select registers; C is a 19-bit signed constant
  assign reg_idx = ({4{Gra}} & ir_q[26:23])
                 | ({4{Grb}} & ir_q[22:19])
                 | ({4{Grc}} & ir_q[18:15]);
  assign c_sext  = {{13{ir_q[18]}}, ir_q[18:0]};

  assign mem_rdata = mem[mar_q[8:0]];

  always_comb begin
    bus = '0;
    if (MBIout) begin
      bus = manualBusInput;
    end else if (Rout || BAout) begin
      // BAout treats R0 as a constant zero (base-address addressing)
      bus = (BAout && (reg_idx == 4'd0)) ? 32'd0 : r_q[reg_idx];
    end else if (PCout) begin
      bus = pc_q;
    end else if (Zlowout) begin
      bus = z_q[31:0];
    end else if (MDRout) begin
      bus = mdr_q;
    end else if (Cout) begin
      bus = c_sext;
    end
  end

  assign BusMuxOut = bus;

  // ALU: A comes from Y, B from the bus
  logic [31:0]        alu_a;
  logic [31:0]        alu_b;
  logic [4:0]         shamt;
  logic signed [31:0] a_signed;
  logic [31:0]        sra_res;
  logic [63:0]        rot_right;
  logic [63:0]        rot_left;
  logic signed [63:0] a_ext;
  logic signed [63:0] b_ext;
  logic signed [63:0] product;

  always_comb begin
    alu_a     = y_q;
    alu_b     = bus;
    shamt     = alu_b[4:0];
    a_signed  = alu_a;
    sra_res   = $unsigned(a_signed >>> shamt);
    rot_right = {alu_a, alu_a} >> shamt;
    rot_left  = {alu_a, alu_a} << shamt;
    a_ext     = {{32{alu_a[31]}}, alu_a};
    b_ext     = {{32{alu_b[31]}}, alu_b};
    product   = a_ext * b_ext;
    alu_res   = '0;
    case (OpCode)
      OP_ADD:  alu_res = {32'd0, alu_a + alu_b};
      OP_SUB:  alu_res = {32'd0, alu_a - alu_b};
      OP_SHR:  alu_res = {32'd0, alu_a >> shamt};
      OP_SHRA: alu_res = {32'd0, sra_res};
      OP_SHL:  alu_res = {32'd0, alu_a << shamt};
      OP_ROR:  alu_res = {32'd0, rot_right[31:0]};
      OP_ROL:  alu_res = {32'd0, rot_left[63:32]};
      OP_AND:  alu_res = {32'd0, alu_a & alu_b};
      OP_OR:   alu_res = {32'd0, alu_a | alu_b};
      OP_NEG:  alu_res = {32'd0, 32'd0 - alu_b};
      OP_INC:  alu_res = {32'd0, alu_b + 32'd1};
      OP_MUL:  alu_res = $unsigned(product);
      OP_NOT:  alu_res = {32'd0, ~alu_b};
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    con_eval = 1'b0;
    case (ir_q[20:19])
      2'b00:   con_eval = (bus == 32'd0);
      2'b01:   con_eval = (bus != 32'd0);
      2'b10:   con_eval = !bus[31] && (bus != 32'd0);
      default: con_eval = bus[31];
    endcase
  end

  always_comb begin
    pc_d   = pc_q;
    ir_d   = ir_q;
    mar_d  = mar_q;
    mdr_d  = mdr_q;
    y_d    = y_q;
    z_d    = z_q;
    con_d  = con_q;
    outp_d = outp_q;
    r_d    = r_q;
    if (PCin)      pc_d   = bus;
    if (IRin)      ir_d   = bus;
    if (MARin)     mar_d  = bus;
    if (MDRin)     mdr_d  = Read ? mem_rdata : bus;
    if (Yin)       y_d    = bus;
    if (Zin)       z_d    = alu_res;
    if (CONin)     con_d  = con_eval;
    if (OutportIn) outp_d = bus;
    if (Rin)       r_d[reg_idx] = bus;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      pc_q   <= '0;
      ir_q   <= '0;
      mar_q  <= '0;
      mdr_q  <= '0;
      y_q    <= '0;
      z_q    <= '0;
      con_q  <= 1'b0;
      outp_q <= '0;
    end else begin
      pc_q   <= pc_d;
      ir_q   <= ir_d;
      mar_q  <= mar_d;
      mdr_q  <= mdr_d;
      y_q    <= y_d;
      z_q    <= z_d;
      con_q  <= con_d;
      outp_q <= outp_d;
    end
  end

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_regfile
      always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
          r_q[gi] <= '0;
        end else begin
          r_q[gi] <= r_d[gi];
        end
      end
    end
  endgenerate

  // Memory is deliberately outside the reset domain so clr leaves its contents intact
  always_ff @(posedge clk) begin
    if (Write) begin
      mem[mar_q[8:0]] <= mdr_q;
    end
  end

  assign OutportData = outp_q;
  assign CON         = con_q;

  logic unused_bits;
  assign unused_bits = ^{mar_q[31:9], ir_q[31:27], z_q[63:32]};

endmodule

// File: tb/tb_datapath_2.sv
// Self-checking bench for datapath_2: reset behaviour, load sequence, bus priority,
// table-driven ALU vectors through a scoreboard, CON conditions and async clear.
module tb_datapath_2;

  logic        clk = 1'b0;
  logic        clr;
  logic        PCout, Zlowout, MDRout, MBIout, Cout, Rout, BAout;
  logic        PCin, IRin, MARin, MDRin, Yin, Zin, Rin, CONin, OutportIn;
  logic        Gra, Grb, Grc, Read, Write;
  logic [4:0]  OpCode;
  logic [31:0] manualBusInput;
  logic [31:0] BusMuxOut;
  logic [31:0] OutportData;
  logic        CON;

  always #5 clk = ~clk;

  datapath_2 dut (
    .clk(clk), .clr(clr),
    .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .MBIout(MBIout), .Cout(Cout),
    .Rout(Rout), .BAout(BAout),
    .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin), .Yin(Yin), .Zin(Zin),
    .Rin(Rin), .CONin(CONin), .OutportIn(OutportIn),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Read(Read), .Write(Write),
    .OpCode(OpCode), .manualBusInput(manualBusInput),
    .BusMuxOut(BusMuxOut), .OutportData(OutportData), .CON(CON)
  );

  typedef struct {
    string       name;
    logic [4:0]  op;
    logic [31:0] y;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
  } alu_vec_t;

  typedef struct {
    logic [1:0]  cond;
    logic [31:0] bus;
    logic        exp;
  } con_vec_t;

  int checks = 0;
  int errors = 0;
  alu_vec_t alu_tbl[$];
  alu_vec_t sb[$];
  con_vec_t con_tbl[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end else begin
      $display("ok   %s value=0x%0h", name, act);
    end
  endtask

  task automatic clear_ctrl();
    PCout = 0; Zlowout = 0; MDRout = 0; MBIout = 0; Cout = 0; Rout = 0; BAout = 0;
    PCin = 0; IRin = 0; MARin = 0; MDRin = 0; Yin = 0; Zin = 0; Rin = 0; CONin = 0;
    OutportIn = 0; Gra = 0; Grb = 0; Grc = 0; Read = 0; Write = 0; OpCode = 5'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    clear_ctrl();
  endtask

  // Caller raises the source enables first; the bus is sampled mid-cycle.
  task automatic sample(output logic [31:0] v);
    #1;
    v = BusMuxOut;
    clear_ctrl();
  endtask

  task automatic drive_bus(input logic [31:0] v);
    MBIout = 1;
    manualBusInput = v;
  endtask

  function automatic alu_vec_t mk_alu(input string n, input logic [4:0] op, input logic [31:0] y,
                                      input logic [31:0] b, input logic [31:0] hi,
                                      input logic [31:0] lo);
    alu_vec_t v;
    v.name = n; v.op = op; v.y = y; v.b = b; v.hi = hi; v.lo = lo;
    return v;
  endfunction

  function automatic con_vec_t mk_con(input logic [1:0] c, input logic [31:0] b, input logic e);
    con_vec_t v;
    v.cond = c; v.bus = b; v.exp = e;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    alu_vec_t e;

    alu_tbl.push_back(mk_alu("add_wrap",  5'd2,  32'hFFFFFFFF, 32'h00000002, 32'h0, 32'h00000001));
    alu_tbl.push_back(mk_alu("sub_neg",   5'd3,  32'h00000005, 32'h00000007, 32'h0, 32'hFFFFFFFE));
    alu_tbl.push_back(mk_alu("shr",       5'd4,  32'h80000000, 32'h00000004, 32'h0, 32'h08000000));
    alu_tbl.push_back(mk_alu("shra",      5'd5,  32'h80000001, 32'h00000001, 32'h0, 32'hC0000000));
    alu_tbl.push_back(mk_alu("shl_amt33", 5'd6,  32'h00000003, 32'h00000021, 32'h0, 32'h00000006));
    alu_tbl.push_back(mk_alu("ror",       5'd7,  32'h80000001, 32'h00000001, 32'h0, 32'hC0000000));
    alu_tbl.push_back(mk_alu("ror_zero",  5'd7,  32'h12345678, 32'h00000020, 32'h0, 32'h12345678));
    alu_tbl.push_back(mk_alu("rol",       5'd8,  32'h80000001, 32'h00000004, 32'h0, 32'h00000018));
    alu_tbl.push_back(mk_alu("and",       5'd9,  32'hF0F0F0F0, 32'h0FF00FF0, 32'h0, 32'h00F000F0));
    alu_tbl.push_back(mk_alu("or",        5'd10, 32'hF0000000, 32'h0000000F, 32'h0, 32'hF000000F));
    alu_tbl.push_back(mk_alu("neg",       5'd11, 32'h00000000, 32'h00000001, 32'h0, 32'hFFFFFFFF));
    alu_tbl.push_back(mk_alu("inc_wrap",  5'd12, 32'h00001234, 32'hFFFFFFFF, 32'h0, 32'h00000000));
    alu_tbl.push_back(mk_alu("mul_neg",   5'd13, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA));
    alu_tbl.push_back(mk_alu("mul_pos",   5'd13, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001));
    alu_tbl.push_back(mk_alu("not",       5'd14, 32'h00000000, 32'h0F0F0F0F, 32'h0, 32'hF0F0F0F0));
    alu_tbl.push_back(mk_alu("op0_zero",  5'd0,  32'h11111111, 32'h22222222, 32'h0, 32'h00000000));
    alu_tbl.push_back(mk_alu("op15_zero", 5'd15, 32'h11111111, 32'h22222222, 32'h0, 32'h00000000));
    alu_tbl.push_back(mk_alu("op31_zero", 5'd31, 32'h11111111, 32'h22222222, 32'h0, 32'h00000000));
    alu_tbl.push_back(mk_alu("add_last",  5'd2,  32'h00000100, 32'h00000023, 32'h0, 32'h00000123));

    con_tbl.push_back(mk_con(2'b11, 32'h80000000, 1'b1));
    con_tbl.push_back(mk_con(2'b00, 32'h80000000, 1'b0));
    con_tbl.push_back(mk_con(2'b01, 32'h00000000, 1'b0));
    con_tbl.push_back(mk_con(2'b01, 32'h00000005, 1'b1));
    con_tbl.push_back(mk_con(2'b10, 32'h00000005, 1'b1));
    con_tbl.push_back(mk_con(2'b10, 32'h00000000, 1'b0));
    con_tbl.push_back(mk_con(2'b10, 32'h80000000, 1'b0));
    con_tbl.push_back(mk_con(2'b11, 32'h00000001, 1'b0));
    con_tbl.push_back(mk_con(2'b00, 32'h00000000, 1'b1));

    // Reset held with enables asserted: nothing may load
    clear_ctrl();
    manualBusInput = '0;
    clr = 0;
    drive_bus(32'h55); PCin = 1; Yin = 1; OutportIn = 1; tick();
    PCout = 1; sample(v); check("rst_pc", v, 32'h0);
    Zlowout = 1; sample(v); check("rst_zlow", v, 32'h0);
    check("rst_outport", OutportData, 32'h0);
    check("rst_con", CON, 1'b0);
    #1 clr = 1;
    drive_bus(32'h55); PCin = 1; tick();
    PCout = 1; sample(v); check("first_load_pc", v, 32'h55);
    clr = 0; #1; clr = 1;
    PCout = 1; sample(v); check("async_clr_pc", v, 32'h0);

    // Load/address-calculation sequence
    drive_bus(32'h00080045); MDRin = 1; tick();
    Write = 1; tick();
    MDRout = 1; IRin = 1; tick();
    drive_bus(32'd74); MARin = 1; tick();
    drive_bus(32'd9); MDRin = 1; tick();
    Write = 1; tick();
    drive_bus(32'd5); Grb = 1; Rin = 1; tick();
    PCout = 1; MARin = 1; Zin = 1; OpCode = 5'd12; tick();
    Zlowout = 1; PCin = 1; tick();
    Read = 1; MDRin = 1; tick();
    MDRout = 1; IRin = 1; tick();
    Grb = 1; BAout = 1; Yin = 1; tick();
    Cout = 1; Zin = 1; OpCode = 5'd2; tick();
    Zlowout = 1; MARin = 1; tick();
    Read = 1; MDRin = 1; tick();
    MDRout = 1; Gra = 1; Rin = 1; tick();
    Zlowout = 1; sample(v); check("ld_z", v, 32'd74);
    Gra = 1; Rout = 1; sample(v); check("ld_r0", v, 32'd9);
    PCout = 1; sample(v); check("ld_pc", v, 32'd1);
    Grb = 1; Rout = 1; sample(v); check("ld_r1", v, 32'd5);
    Cout = 1; sample(v); check("ld_c", v, 32'h45);
    MDRout = 1; sample(v); check("ld_mdr", v, 32'd9);

    // Self-referencing loads capture the pre-edge value
    Zlowout = 1; Zin = 1; OpCode = 5'd12; tick();
    Zlowout = 1; sample(v); check("self_z_inc", v, 32'd75);
    PCout = 1; PCin = 1; tick();
    PCout = 1; sample(v); check("self_pc_hold", v, 32'd1);

    // Bus priority
    drive_bus(32'hAAAA); PCout = 1; Zlowout = 1; sample(v); check("prio_mbi", v, 32'hAAAA);
    Gra = 1; Rout = 1; PCout = 1; sample(v); check("prio_rout", v, 32'd9);
    PCout = 1; Zlowout = 1; sample(v); check("prio_pc", v, 32'd1);
    Zlowout = 1; MDRout = 1; sample(v); check("prio_zlow", v, 32'd75);
    MDRout = 1; Cout = 1; sample(v); check("prio_mdr", v, 32'd9);
    sample(v); check("prio_none", v, 32'h0);

    // BAout vs Rout with Rb selecting R0; Rc selection
    drive_bus(32'h00018000); IRin = 1; tick();
    drive_bus(32'h1234); Gra = 1; Rin = 1; tick();
    Grb = 1; BAout = 1; sample(v); check("baout_r0_bus", v, 32'h0);
    Grb = 1; BAout = 1; Yin = 1; tick();
    Zin = 1; OpCode = 5'd2; tick();
    Zlowout = 1; sample(v); check("baout_y", v, 32'h0);
    Grb = 1; Rout = 1; Yin = 1; tick();
    Zin = 1; OpCode = 5'd2; tick();
    Zlowout = 1; sample(v); check("rout_y", v, 32'h1234);
    drive_bus(32'hCAFE0003); Grc = 1; Rin = 1; tick();
    Grc = 1; Rout = 1; sample(v); check("rc_r3", v, 32'hCAFE0003);
    Gra = 1; Rout = 1; sample(v); check("r0_kept", v, 32'h1234);

    // ALU vectors through the scoreboard
    for (int i = 0; i < alu_tbl.size(); i++) begin
      drive_bus(alu_tbl[i].y); Yin = 1; tick();
      drive_bus(alu_tbl[i].b); Zin = 1; OpCode = alu_tbl[i].op;
      sb.push_back(alu_tbl[i]);
      tick();
      e = sb.pop_front();
      Zlowout = 1; sample(v);
      check({"alu_lo_", e.name}, v, e.lo);
      check({"alu_hi_", e.name}, dut.z_q[63:32], e.hi);
    end

    // Branch condition
    for (int i = 0; i < con_tbl.size(); i++) begin
      drive_bus({11'd0, con_tbl[i].cond, 19'd0}); IRin = 1; tick();
      drive_bus(con_tbl[i].bus); CONin = 1; tick();
      check($sformatf("con_%0d", i), CON, con_tbl[i].exp);
    end

    drive_bus(32'hDEADBEEF); OutportIn = 1; tick();
    check("outport", OutportData, 32'hDEADBEEF);

    // Asynchronous clear mid-sequence, memory survives
    clr = 0;
    #1;
    PCout = 1; sample(v); check("clr_pc", v, 32'h0);
    Zlowout = 1; sample(v); check("clr_z", v, 32'h0);
    Gra = 1; Rout = 1; sample(v); check("clr_r0", v, 32'h0);
    MDRout = 1; sample(v); check("clr_mdr", v, 32'h0);
    check("clr_outport", OutportData, 32'h0);
    check("clr_con", CON, 1'b0);
    check("clr_zhi", dut.z_q[63:32], 32'h0);
    clr = 1;
    Zin = 1; OpCode = 5'd2; tick();
    Zlowout = 1; sample(v); check("clr_y", v, 32'h0);
    Read = 1; MDRin = 1; tick();
    MDRout = 1; sample(v); check("mem0_kept", v, 32'h00080045);
    drive_bus(32'd74); MARin = 1; tick();
    Read = 1; MDRin = 1; tick();
    MDRout = 1; sample(v); check("mem74_kept", v, 32'd9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/datapath_2.md
DATAPATH_2 -- requirements
Module: datapath_2

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 clr  in  1  reset, asynchronous, active-low.
REQ-003 PCout, Zlowout, MDRout, MBIout, Cout  in  1 each  bus-source enables: PC, Z[31:0], MDR, manualBusInput, sign-extended C.
REQ-004 Rout, BAout  in  1 each  drive the selected general register onto the bus; under BAout, R0 drives 0.
REQ-005 PCin, IRin, MARin, MDRin, Yin, Zin, Rin, CONin, OutportIn  in  1 each  load enables for PC, IR, MAR, MDR, Y, Z, selected register, CON flag, output port.
REQ-006 Gra, Grb, Grc  in  1 each  register-select strobes using IR fields Ra, Rb, Rc.
REQ-007 Read, Write  in  1 each  memory read select into MDR; memory write strobe.
REQ-008 OpCode  in  5  ALU operation select.
REQ-009 manualBusInput  in  32  external bus value, driven when MBIout=1.
REQ-010 BusMuxOut  out  32  current bus value.
REQ-011 OutportData  out  32  output port register.
REQ-012 CON  out  1  branch condition flag.

Function
REQ-013 Bus SHALL be a 32-bit mux; priority: MBIout > Rout/BAout > PCout > Zlowout > MDRout > Cout; no enable -> 0.
REQ-014 IR fields SHALL be: Ra=IR[26:23], Rb=IR[22:19], Rc=IR[18:15], C=IR[18:0] sign-extended to 32 bits.
REQ-015 Register index SHALL be the OR of (Gra&Ra, Grb&Rb, Grc&Rc); Rin writes bus into R[index] at clock edge; R0 is writable.
REQ-016 Register file SHALL be R0-R15, 32 bits each.
REQ-017 MDR input SHALL be memory read data when Read=1, else bus; loaded when MDRin=1.
REQ-018 Memory SHALL be 512x32, address MAR[8:0]; reads combinational; Write=1 stores current MDR register contents at the rising edge.
REQ-019 ALU SHALL take A=Y, B=bus; 64-bit result loaded into Z when Zin=1.
REQ-020 OpCode 2 ADD, Z=A+B (Zlow; Zhigh=0).
REQ-021 OpCode 3 SUB A-B; 4 SHR A>>B[4:0]; 5 SHRA arithmetic; 6 SHL; 7 ROR; 8 ROL (amount B[4:0]).
REQ-022 OpCode 9 AND; 10 OR; 11 NEG (-B); 14 NOT (~B); 12 INC (B+1, Y ignored).
REQ-023 OpCode 13 MUL: signed A*B, full 64-bit into Z.
REQ-024 Other OpCodes SHALL produce Z=0; 32-bit results zero Zhigh; add/sub wrap modulo 2^32.
REQ-025 CON on CONin SHALL evaluate bus with IR[20:19]: 00 bus==0, 01 bus!=0, 10 bus[31]=0 and nonzero, 11 bus[31]=1.
REQ-026 OutportIn SHALL load bus into OutportData.
REQ-027 A register load with its own value on bus (e.g. PCout+PCin) SHALL capture the pre-edge value.

Reset
REQ-028 clr=0 SHALL immediately clear PC, IR, MAR, MDR, Y, Z, R0-R15, CON, OutportData to 0.
REQ-029 Memory contents SHALL be unaffected by clr; power-up contents 0.
REQ-030 Enables asserted during reset SHALL be ignored until clr returns high; first load on the following edge.

Verification
REQ-031 Load: MAR=0, MDR=0x00080045 + Write, IR<-MDR; MAR=74, MDR=9 + Write; R1=5 via Grb+Rin; PCout+MARin+Zin OpCode 12; Zlowout+PCin; Read+MDRin; IR<-MDR; Grb+BAout+Yin; Cout+Zin OpCode 2; Zlowout+MARin; Read+MDRin; MDRout+Gra+Rin -> Z=74, R0=9, PC=1.
REQ-032 BAout with Rb=R0 holding 0x1234 -> Y=0; Rout -> Y=0x1234.
REQ-033 Y=0xFFFFFFFE, bus=3, OpCode 13 -> Z=0xFFFFFFFF_FFFFFFFA.
REQ-034 IR[20:19]=11, bus=0x80000000, CONin -> CON=1; IR[20:19]=00, same bus -> CON=0.
REQ-035 Y=0x80000001, bus=1: OpCode 7 -> Zlow=0xC0000000; OpCode 5 -> Zlow=0xC0000000.
REQ-036 clr pulsed low mid-sequence -> all registers 0 asynchronously; memory keeps 74->9.
